sisc_rf_trace: RTL and testbench
================================

Name: sisc_rf_trace

Overview:
- Synthesizable trace capture unit for the SISC register file. Generalises the bench-side register monitor into hardware.
- Snoops the register-file write port and filters writes by a per-register watch mask and an optional change-only rule.
- Timestamps each accepted write and buffers it in a DEPTH-entry FIFO that the bench or a debug port drains through a valid/ack handshake.
- Sits beside the sisc register file, driven by the same clock and reset.

Parameters:
- DATA_W, 32: register data width.
- ADDR_W, 4: register address width; 2^ADDR_W registers.
- DEPTH, 16: FIFO entries. Must be a power of 2 and at least 2.
- TS_W, 16: timestamp counter width.
- WATCH_MASK, 16'h000E: bit i set means register i is traced. Default traces R1..R3. Width is 2^ADDR_W.
- CHANGE_ONLY, 1: when 1, trace only writes whose data differs from the register's last written value.
- WRAP, 0: 0 selects stop-on-full; 1 selects overwrite-oldest.

Ports:
- clk  in  1  system clock
- rst_f  in  1  synchronous active-low reset
- arm  in  1  level; 1 enables capture
- clr  in  1  pulse; flush FIFO, clear overflow, go to IDLE
- rf_we  in  1  register-file write enable (snooped)
- rf_waddr  in  ADDR_W  register-file write address
- rf_wdata  in  DATA_W  register-file write data
- rd_ack  in  1  pop head entry when rd_valid=1
- rd_valid  out  1  FIFO non-empty
- rd_ts  out  TS_W  head entry timestamp
- rd_addr  out  ADDR_W  head entry register address
- rd_data  out  DATA_W  head entry data
- count  out  clog2(DEPTH+1)  entries held
- overflow  out  1  sticky: at least one event was lost or overwritten
- state  out  2  0=IDLE, 1=CAPTURE, 2=FROZEN

Behaviour:
- Reset: when rst_f=0 at a rising edge, the following clear: ts counter, shadow registers, FIFO pointers, count, overflow, state=IDLE.
  - Post-reset outputs: rd_valid=0, count=0, overflow=0, state=0.
  - rd_ts/rd_addr/rd_data are don't-care while rd_valid=0.
  - Reset overrides every other input, including mid-capture.
- Timestamp: free-running counter, +1 every cycle after reset, wraps from 2^TS_W-1 to 0.
- Shadow: every rf_we=1 updates shadow[rf_waddr]<=rf_wdata, regardless of mask, state or arm.
- Event (cycle N) requires all of:
  - state=CAPTURE;
  - rf_we=1;
  - WATCH_MASK[rf_waddr]=1;
  - CHANGE_ONLY=0, or rf_wdata != shadow[rf_waddr] as sampled before this cycle's update.
- Recorded entry: {ts value in cycle N, rf_waddr, rf_wdata}.
- Latency: an event written into an empty FIFO gives rd_valid=1 in cycle N+1.
- Read side:
  - Show-ahead: rd_ts/rd_addr/rd_data always present the head entry.
  - rd_ack with rd_valid=1 pops at the clock edge.
  - rd_ack with rd_valid=0 is ignored.
  - Reads are permitted in every state.
- FSM:
  - IDLE -> CAPTURE when arm=1.
  - CAPTURE -> IDLE when arm=0.
  - CAPTURE -> FROZEN (WRAP=0 only) when an event arrives while count=DEPTH and no pop occurs that cycle. That event is dropped and overflow<=1.
  - FROZEN: no captures. Leaves only on clr or reset; arm is ignored.
  - clr=1 (any state): empty FIFO, count=0, overflow=0, state=IDLE. Any event or pop in the same cycle is discarded. The ts counter and shadow registers are not cleared.
- Full boundary:
  - Event + pop when count=DEPTH: pop the head, push the new entry, count unchanged, no overflow. Same in both modes.
  - WRAP=1, event without pop when count=DEPTH: advance the read pointer (drop oldest), write the new entry, count stays DEPTH, overflow<=1, state stays CAPTURE.
- Empty boundary: an event arriving while count=0 with rd_ack=1 is pushed; the ack is ignored.
- count: +1 on push-only, -1 on pop-only, unchanged otherwise. It never exceeds DEPTH.
- Pointers: log2(DEPTH) bits each, wrap naturally.

Test Plan:
- Reset, arm=1, write R1=0x5 at ts=3 -> rd_valid=1 next cycle; head {ts=3, addr=1, data=0x5}; count=1; rd_ack pops -> count=0, rd_valid=0.
- Change filter (CHANGE_ONLY=1): write R2=0x7, then R2=0x7, then R2=0x8; also write R4=0x9 (unmasked) -> exactly two entries, data 0x7 then 0x8; no entry for R4.
- Stop-on-full (WRAP=0, DEPTH=4): 5 masked changing writes with no acks -> count=4, overflow=1, state=FROZEN; arm toggling leaves state FROZEN; clr -> count=0, overflow=0, state=IDLE.
- Wrap mode (WRAP=1, DEPTH=4): write R1 = 1,2,3,4,5,6 -> count=4, overflow=1, state=CAPTURE; pops return data 3,4,5,6 in order.
- Full with simultaneous event and ack (DEPTH=4, full with 1..4, write R3=9 with rd_ack) -> count=4, overflow=0; remaining order 2,3,4,9.
- Mid-capture reset: rst_f=0 for one cycle with count=3 -> count=0, state=IDLE, overflow=0; ts restarts at 0; next recorded event shows the post-reset timestamp.

Source files
------------

// File: rtl/sisc_rf_trace.sv
// sisc_rf_trace: trace capture unit for the SISC register file.
// Snoops the register-file write port and keeps a timestamped record of
// writes to watched registers. With CHANGE_ONLY set, it records only writes
// that change a register's value. Records are buffered in a show-ahead FIFO
// that is drained through rd_valid/rd_ack.
module sisc_rf_trace #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16,
    parameter logic [(1<<ADDR_W)-1:0] WATCH_MASK = 16'h000E,
    parameter bit CHANGE_ONLY = 1'b1,
    parameter bit WRAP        = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_f,
    input  logic                         arm,
    input  logic                         clr,
    input  logic                         rf_we,
    input  logic [ADDR_W-1:0]            rf_waddr,
    input  logic [DATA_W-1:0]            rf_wdata,
    input  logic                         rd_ack,
    output logic                         rd_valid,
    output logic [TS_W-1:0]              rd_ts,
    output logic [ADDR_W-1:0]            rd_addr,
    output logic [DATA_W-1:0]            rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic [1:0]                   state
);

    // state    | meaning
    // IDLE     | not capturing; waits for arm
    // CAPTURE  | watched writes are recorded into the FIFO
    // FROZEN   | FIFO overflowed in stop-on-full mode; only clr or reset leave

    localparam int NREG  = 1 << ADDR_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FROZEN  = 2'd2
    } state_t;

    state_t              st;
    logic [TS_W-1:0]     ts;
    logic [DATA_W-1:0]   shadow [NREG];
    logic [TS_W-1:0]     mem_ts   [DEPTH];
    logic [ADDR_W-1:0]   mem_addr [DEPTH];
    logic [DATA_W-1:0]   mem_data [DEPTH];
    logic [PTR_W-1:0]    rptr;
    logic [PTR_W-1:0]    wptr;

    logic is_full;
    logic is_empty;
    logic changed;
    logic event_hit;
    logic pop;
    logic push;
    logic drop_oldest;
    logic lost;

    // Decode this cycle's event and the resulting FIFO actions.
    always_comb begin
        is_full     = (count == CNT_W'(DEPTH));
        is_empty    = (count == '0);
        changed     = (rf_wdata != shadow[rf_waddr]);
        event_hit   = (st == ST_CAPTURE) && rf_we && WATCH_MASK[rf_waddr] &&
                      (!CHANGE_ONLY || changed);
        pop         = rd_ack && !is_empty;
        // A full FIFO still accepts the event if the head leaves this cycle,
        // or in wrap mode, where the oldest entry is sacrificed instead.
        push        = event_hit && (!is_full || pop || WRAP);
        drop_oldest = event_hit && is_full && !pop && WRAP;
        lost        = event_hit && is_full && !pop;
    end

    // Free-running timestamp, wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst_f) ts <= '0;
        else        ts <= ts + TS_W'(1);
    end

    // Last written value per register, tracked for every write regardless of mask or state.
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            for (int i = 0; i < NREG; i++) shadow[i] <= '0;
        end else if (rf_we) begin
            shadow[rf_waddr] <= rf_wdata;
        end
    end

    // FIFO storage; contents need no reset because count qualifies them.
    always_ff @(posedge clk) begin
        if (rst_f && !clr && push) begin
            mem_ts[wptr]   <= ts;
            mem_addr[wptr] <= rf_waddr;
            mem_data[wptr] <= rf_wdata;
        end
    end

    // FIFO pointers, occupancy, sticky overflow and capture state machine.
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            st       <= ST_IDLE;
        end else if (clr) begin
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            st       <= ST_IDLE;
        end else begin
            if (push)
                wptr <= wptr + PTR_W'(1);
            if (pop || drop_oldest)
                rptr <= rptr + PTR_W'(1);
            if (push && !pop && !drop_oldest)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
            if (lost)
                overflow <= 1'b1;

            case (st)
                ST_IDLE: begin
                    if (arm) st <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (lost && !WRAP) st <= ST_FROZEN;
                    else if (!arm)     st <= ST_IDLE;
                end
                ST_FROZEN: st <= ST_FROZEN;
                default:   st <= ST_IDLE;
            endcase
        end
    end

    assign rd_valid = !is_empty;
    assign rd_ts    = mem_ts[rptr];
    assign rd_addr  = mem_addr[rptr];
    assign rd_data  = mem_data[rptr];
    assign state    = st;

endmodule

// File: tb/tb_sisc_rf_trace.sv
// Directed bench for sisc_rf_trace. Two instances share the same stimulus:
// dut_a is stop-on-full and dut_w is overwrite-oldest, both with DEPTH=4.
module tb_sisc_rf_trace;

    logic        clk = 1'b0;
    logic        rst_f, arm, clr, rf_we, rd_ack;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic        a_rd_valid, w_rd_valid;
    logic [15:0] a_rd_ts, w_rd_ts;
    logic [3:0]  a_rd_addr, w_rd_addr;
    logic [31:0] a_rd_data, w_rd_data;
    logic [2:0]  a_count, w_count;
    logic        a_overflow, w_overflow;
    logic [1:0]  a_state, w_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sisc_rf_trace #(.DEPTH(4), .WRAP(1'b0)) dut_a (
        .clk(clk), .rst_f(rst_f), .arm(arm), .clr(clr), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rd_ack(rd_ack),
        .rd_valid(a_rd_valid), .rd_ts(a_rd_ts), .rd_addr(a_rd_addr),
        .rd_data(a_rd_data), .count(a_count), .overflow(a_overflow),
        .state(a_state)
    );

    sisc_rf_trace #(.DEPTH(4), .WRAP(1'b1)) dut_w (
        .clk(clk), .rst_f(rst_f), .arm(arm), .clr(clr), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rd_ack(rd_ack),
        .rd_valid(w_rd_valid), .rd_ts(w_rd_ts), .rd_addr(w_rd_addr),
        .rd_data(w_rd_data), .count(w_count), .overflow(w_overflow),
        .state(w_state)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_f = 1'b0; arm = 1'b0; clr = 1'b0; rf_we = 1'b0; rd_ack = 1'b0;
        rf_waddr = '0; rf_wdata = '0;
        tick();
        tick();
        rst_f = 1'b1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
        tick();
        rf_we = 1'b0;
    endtask

    task automatic pop();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
    endtask

    logic [31:0] exp_a [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
    logic [31:0] exp_w [4] = '{32'd3, 32'd4, 32'd5, 32'd6};
    logic [31:0] exp_s [4] = '{32'd2, 32'd3, 32'd4, 32'd9};

    initial begin
        // Reset state; ts is 0 in the cycle after the last reset edge.
        do_reset();
        check_val("rst_valid", 32'(a_rd_valid), 32'd0);
        check_val("rst_count", 32'(a_count), 32'd0);
        check_val("rst_ovf",   32'(a_overflow), 32'd0);
        check_val("rst_state", 32'(a_state), 32'd0);

        // Single event at ts=3 appears on the following cycle.
        arm = 1'b1;
        tick();
        check_val("arm_state", 32'(a_state), 32'd1);
        tick();
        tick();
        wr(4'd1, 32'h5);
        check_val("t1_valid", 32'(a_rd_valid), 32'd1);
        check_val("t1_ts",    32'(a_rd_ts), 32'd3);
        check_val("t1_addr",  32'(a_rd_addr), 32'd1);
        check_val("t1_data",  a_rd_data, 32'h5);
        check_val("t1_count", 32'(a_count), 32'd1);
        pop();
        check_val("t1_pop_count", 32'(a_count), 32'd0);
        check_val("t1_pop_valid", 32'(a_rd_valid), 32'd0);

        // Change-only filter plus an unwatched register.
        wr(4'd2, 32'h7);
        wr(4'd2, 32'h7);
        wr(4'd2, 32'h8);
        wr(4'd4, 32'h9);
        check_val("chg_count", 32'(a_count), 32'd2);
        check_val("chg_addr0", 32'(a_rd_addr), 32'd2);
        check_val("chg_data0", a_rd_data, 32'h7);
        pop();
        check_val("chg_data1", a_rd_data, 32'h8);
        pop();
        check_val("chg_empty", 32'(a_count), 32'd0);

        // Fill past capacity: dut_a freezes, dut_w overwrites oldest.
        do_reset();
        arm = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) wr(4'd1, 32'(i));
        check_val("full_count", 32'(a_count), 32'd4);
        check_val("full_ovf",   32'(a_overflow), 32'd0);
        wr(4'd1, 32'd5);
        wr(4'd1, 32'd6);
        check_val("stop_count", 32'(a_count), 32'd4);
        check_val("stop_ovf",   32'(a_overflow), 32'd1);
        check_val("stop_state", 32'(a_state), 32'd2);
        check_val("wrap_count", 32'(w_count), 32'd4);
        check_val("wrap_ovf",   32'(w_overflow), 32'd1);
        check_val("wrap_state", 32'(w_state), 32'd1);
        arm = 1'b0;
        tick();
        arm = 1'b1;
        tick();
        check_val("frozen_arm", 32'(a_state), 32'd2);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("stop_pop%0d", i), a_rd_data, exp_a[i]);
            check_val($sformatf("wrap_pop%0d", i), w_rd_data, exp_w[i]);
            pop();
        end
        check_val("stop_drained", 32'(a_count), 32'd0);
        check_val("stop_ovf_sticky", 32'(a_overflow), 32'd1);
        // clr discards an event arriving in the same cycle.
        clr = 1'b1; rf_we = 1'b1; rf_waddr = 4'd1; rf_wdata = 32'd7;
        tick();
        clr = 1'b0; rf_we = 1'b0;
        check_val("clr_count", 32'(a_count), 32'd0);
        check_val("clr_ovf",   32'(a_overflow), 32'd0);
        check_val("clr_state", 32'(a_state), 32'd0);
        check_val("clr_w_count", 32'(w_count), 32'd0);

        // Event plus ack at full: both modes pop and push, no overflow.
        do_reset();
        arm = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) wr(4'd1, 32'(i));
        rd_ack = 1'b1;
        wr(4'd3, 32'd9);
        rd_ack = 1'b0;
        check_val("simul_count_a", 32'(a_count), 32'd4);
        check_val("simul_ovf_a",   32'(a_overflow), 32'd0);
        check_val("simul_count_w", 32'(w_count), 32'd4);
        check_val("simul_ovf_w",   32'(w_overflow), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("simul_a%0d", i), a_rd_data, exp_s[i]);
            check_val($sformatf("simul_w%0d", i), w_rd_data, exp_s[i]);
            pop();
        end

        // Empty FIFO: ack alongside an event is ignored, event is kept.
        rd_ack = 1'b1;
        wr(4'd2, 32'hA);
        rd_ack = 1'b0;
        check_val("empty_ack_count", 32'(a_count), 32'd1);
        check_val("empty_ack_data",  a_rd_data, 32'hA);
        pop();

        // Mid-capture reset, then timestamp restarts from 0.
        wr(4'd1, 32'h11);
        wr(4'd1, 32'h12);
        wr(4'd1, 32'h13);
        check_val("mid_count", 32'(a_count), 32'd3);
        rst_f = 1'b0;
        tick();
        rst_f = 1'b1;
        check_val("mid_rst_count", 32'(a_count), 32'd0);
        check_val("mid_rst_state", 32'(a_state), 32'd0);
        check_val("mid_rst_ovf",   32'(a_overflow), 32'd0);
        check_val("mid_rst_valid", 32'(a_rd_valid), 32'd0);
        tick();
        wr(4'd2, 32'h55);
        check_val("mid_ts",   32'(a_rd_ts), 32'd1);
        check_val("mid_addr", 32'(a_rd_addr), 32'd2);
        check_val("mid_data", a_rd_data, 32'h55);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
